// File: rtl/axi_inst_read_bridge_if.sv
// Bundle of the fetch-side request/response signals and the AXI4 read
// address/data channels of the instruction read bridge.
// slave  : view of the bridge itself (takes fetch requests, drives AR, takes R).
// master : view of the surrounding environment (fetch stage plus interconnect).
// When RRESP_ERR_EN is defined the bundle also carries axi_err.
interface axi_inst_read_bridge_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
);
    // fetch-stage user side
    logic              axi_start;
    logic [ADDR_W-1:0] axi_addr;
    logic              axi_done;
    logic [31:0]       axi_rdata;
    logic              axi_busy;
`ifdef RRESP_ERR_EN
    logic              axi_err;
`endif
    // AXI4 read address channel
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    // AXI4 read data channel
    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  axi_start, axi_addr,
        output axi_done, axi_rdata, axi_busy,
`ifdef RRESP_ERR_EN
        output axi_err,
`endif
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport master (
        output axi_start, axi_addr,
        input  axi_done, axi_rdata, axi_busy,
`ifdef RRESP_ERR_EN
        input  axi_err,
`endif
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_inst_read_bridge.sv
// Instruction fetch AXI read bridge: each one-cycle axi_start becomes one
// single-beat AXI4 read (AR then R); the returned word is presented on
// axi_rdata with a one-cycle axi_done pulse. One transaction outstanding.
// Handshakes: a transfer happens on a channel exactly in the cycle where both
// valid and ready are high; arvalid/araddr never change while waiting for
// arready, and rready is only high in the R state.
// Optional feature macro: RRESP_ERR_EN (adds axi_err, replaces errored data
// with a NOP word 32'h0000_0000).
// dbg_state exposes the FSM state: 0=IDLE 1=AR 2=R 3=DONE.
module axi_inst_read_bridge #(
    parameter int ID_W   = 4,
    parameter int AR_ID  = 0,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    axi_inst_read_bridge_if.slave bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;

    // fixed attributes of every request: single 4-byte INCR beat, instruction access
    assign bus.arid    = ID_W'(AR_ID);
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'b0000;
    assign bus.arprot  = 3'b100;

    assign dbg_state = state;

    // rid and rlast carry no information for a single-beat, single-ID read
`ifdef RRESP_ERR_EN
    logic unused_inputs;
    assign unused_inputs = ^{bus.rid, bus.rlast};
`else
    logic unused_inputs;
    assign unused_inputs = ^{bus.rid, bus.rlast, bus.rresp};
`endif

    // request FSM with all handshake and user outputs registered
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            bus.araddr    <= '0;
            bus.arvalid   <= 1'b0;
            bus.rready    <= 1'b0;
            bus.axi_done  <= 1'b0;
            bus.axi_busy  <= 1'b0;
            bus.axi_rdata <= 32'h0;
`ifdef RRESP_ERR_EN
            bus.axi_err   <= 1'b0;
`endif
        end else begin
            bus.axi_done <= 1'b0;
`ifdef RRESP_ERR_EN
            bus.axi_err  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.axi_start) begin
                        bus.araddr   <= bus.axi_addr;
                        bus.arvalid  <= 1'b1;
                        bus.axi_busy <= 1'b1;
                        state        <= S_AR;
                    end
                end
                S_AR: begin
                    if (bus.arvalid && bus.arready) begin
                        bus.arvalid <= 1'b0;
                        bus.rready  <= 1'b1;
                        state       <= S_R;
                    end
                end
                S_R: begin
                    if (bus.rvalid && bus.rready) begin
                        bus.rready   <= 1'b0;
                        bus.axi_busy <= 1'b0;
                        bus.axi_done <= 1'b1;
`ifdef RRESP_ERR_EN
                        if (bus.rresp != 2'b00) begin
                            bus.axi_rdata <= 32'h0000_0000;
                            bus.axi_err   <= 1'b1;
                        end else begin
                            bus.axi_rdata <= bus.rdata;
                        end
`else
                        bus.axi_rdata <= bus.rdata;
`endif
                        state <= S_DONE;
                    end
                end
                default: begin
                    // DONE lasts exactly one cycle; starts seen here are dropped
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_inst_read_bridge.sv
// Directed bench for axi_inst_read_bridge with a response scoreboard.
module tb_axi_inst_read_bridge;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int W      = 33;  // {err, rdata}

    logic       clk;
    logic       resetn;
    logic [1:0] dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;

    logic [W-1:0] exp_q[$];

    axi_inst_read_bridge_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) bus ();

    axi_inst_read_bridge #(.ID_W(ID_W), .AR_ID(0), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs and samples are taken 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [1:0] resp);
`ifdef RRESP_ERR_EN
        if (resp != 2'b00) exp_q.push_back({1'b1, 32'h0});
        else               exp_q.push_back({1'b0, data});
`else
        exp_q.push_back({1'b0, data});
        if (resp != 2'b00) begin end
`endif
    endtask

    // scoreboard: every done pulse must match the oldest expected response
    always @(negedge clk) begin
        if (resetn === 1'b1 && bus.axi_done === 1'b1) begin
            logic [W-1:0] e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(bus.axi_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("done_rdata", 64'(bus.axi_rdata), 64'(e[31:0]));
`ifdef RRESP_ERR_EN
                check("done_err", 64'(bus.axi_err), 64'(e[32]));
`endif
            end
        end
`ifdef RRESP_ERR_EN
        if (resetn === 1'b1 && bus.axi_err === 1'b1 && bus.axi_done !== 1'b1)
            check("err_without_done", 64'(bus.axi_done), 64'd1);
`endif
        if (resetn === 1'b1 && bus.arvalid === 1'b1 && bus.rready === 1'b1)
            check("arvalid_rready_overlap", 64'(bus.rready), 64'd0);
    end

    initial begin
        int d0;
        resetn        = 1'b0;
        bus.axi_start = 1'b0;
        bus.axi_addr  = '0;
        bus.arready   = 1'b0;
        bus.rid       = '0;
        bus.rdata     = 32'h0;
        bus.rresp     = 2'b00;
        bus.rlast     = 1'b1;
        bus.rvalid    = 1'b0;

        // 1: reset values
        step();
        step();
        check("rst_state",   64'(dbg_state), 64'd0);
        check("rst_arvalid", 64'(bus.arvalid), 64'd0);
        check("rst_rready",  64'(bus.rready), 64'd0);
        check("rst_done",    64'(bus.axi_done), 64'd0);
        check("rst_busy",    64'(bus.axi_busy), 64'd0);
        check("rst_rdata",   64'(bus.axi_rdata), 64'd0);
        check("rst_araddr",  64'(bus.araddr), 64'd0);
        resetn = 1'b1;
        step();

        // 2: minimum latency with arready/rvalid held high
        bus.arready = 1'b1;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h2408_0001;
        bus.axi_addr  = 32'h0000_0010;
        bus.axi_start = 1'b1;
        push_exp(32'h2408_0001, 2'b00);
        step();                                   // T+1
        bus.axi_start = 1'b0;
        check("t2_arvalid_t1", 64'(bus.arvalid), 64'd1);
        check("t2_araddr",     64'(bus.araddr), 64'h10);
        check("t2_busy_t1",    64'(bus.axi_busy), 64'd1);
        check("t2_rready_t1",  64'(bus.rready), 64'd0);
        check("t2_arlen",      64'(bus.arlen), 64'd0);
        check("t2_arsize",     64'(bus.arsize), 64'd2);
        check("t2_arburst",    64'(bus.arburst), 64'd1);
        check("t2_arprot",     64'(bus.arprot), 64'd4);
        check("t2_arid",       64'(bus.arid), 64'd0);
        check("t2_arcache",    64'(bus.arcache), 64'd0);
        step();                                   // T+2
        check("t2_rready_t2",  64'(bus.rready), 64'd1);
        check("t2_arvalid_t2", 64'(bus.arvalid), 64'd0);
        check("t2_busy_t2",    64'(bus.axi_busy), 64'd1);
        step();                                   // T+3
        check("t2_done_t3",    64'(bus.axi_done), 64'd1);
        check("t2_busy_t3",    64'(bus.axi_busy), 64'd0);
        check("t2_rready_t3",  64'(bus.rready), 64'd0);
        step();
        check("t2_done_t4",    64'(bus.axi_done), 64'd0);
        check("t2_state_t4",   64'(dbg_state), 64'd0);
        check("t2_rdata_hold", 64'(bus.axi_rdata), 64'h2408_0001);

        // 3: back-pressure on AR and late R beat; misaligned address passes unmodified
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        d0 = done_cnt;
        bus.axi_addr  = 32'h0000_0013;
        bus.axi_start = 1'b1;
        push_exp(32'h1234_5678, 2'b00);
        step();
        bus.axi_start = 1'b0;
        bus.axi_addr  = 32'hFFFF_FFF0;
        for (int i = 0; i < 5; i++) begin
            check("t3_arvalid_hold", 64'(bus.arvalid), 64'd1);
            check("t3_araddr_hold",  64'(bus.araddr), 64'h13);
            check("t3_rready_ar",    64'(bus.rready), 64'd0);
            step();
        end
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
        check("t3_rready_r", 64'(bus.rready), 64'd1);
        check("t3_arvalid_r", 64'(bus.arvalid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_rready_wait", 64'(bus.rready), 64'd1);
        end
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1234_5678;
        step();
        bus.rvalid = 1'b0;
        check("t3_done", 64'(bus.axi_done), 64'd1);
        step();
        step();
        check("t3_one_done", 64'(done_cnt - d0), 64'd1);

        // 4: starts during R and DONE are dropped
        bus.arready = 1'b1;
        d0 = done_cnt;
        bus.axi_addr  = 32'h0000_0010;
        bus.axi_start = 1'b1;
        push_exp(32'hA5A5_0001, 2'b00);
        step();                                   // AR
        bus.axi_start = 1'b0;
        step();                                   // R
        bus.axi_addr  = 32'h0000_0020;
        bus.axi_start = 1'b1;
        step();
        bus.axi_start = 1'b0;
        check("t4_state_r",   64'(dbg_state), 64'd2);
        check("t4_araddr_r",  64'(bus.araddr), 64'h10);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hA5A5_0001;
        step();                                   // DONE
        bus.rvalid = 1'b0;
        check("t4_done", 64'(bus.axi_done), 64'd1);
        bus.axi_start = 1'b1;
        step();                                   // IDLE, start in DONE dropped
        bus.axi_start = 1'b0;
        check("t4_idle",       64'(dbg_state), 64'd0);
        check("t4_arvalid_no", 64'(bus.arvalid), 64'd0);
        check("t4_araddr_kept", 64'(bus.araddr), 64'h10);
        step();
        check("t4_one_done", 64'(done_cnt - d0), 64'd1);
        bus.axi_start = 1'b1;
        push_exp(32'hA5A5_0002, 2'b00);
        step();
        bus.axi_start = 1'b0;
        check("t4_araddr_20", 64'(bus.araddr), 64'h20);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hA5A5_0002;
        step();
        step();
        bus.rvalid = 1'b0;
        check("t4_done2", 64'(bus.axi_done), 64'd1);
        step();

        // 5: error response
        bus.axi_addr  = 32'h0000_0040;
        bus.axi_start = 1'b1;
        push_exp(32'hDEAD_BEEF, 2'b10);
        step();
        bus.axi_start = 1'b0;
        bus.rvalid = 1'b1;
        bus.rresp  = 2'b10;
        bus.rdata  = 32'hDEAD_BEEF;
        step();
        step();
        bus.rvalid = 1'b0;
        bus.rresp  = 2'b00;
        check("t5_done", 64'(bus.axi_done), 64'd1);
`ifdef RRESP_ERR_EN
        check("t5_err",   64'(bus.axi_err), 64'd1);
        check("t5_rdata", 64'(bus.axi_rdata), 64'h0);
`else
        check("t5_rdata", 64'(bus.axi_rdata), 64'hDEAD_BEEF);
`endif
        step();

        // 6: reset while R beat pending abandons the transaction
        bus.rvalid = 1'b0;
        d0 = done_cnt;
        bus.axi_addr  = 32'h0000_0080;
        bus.axi_start = 1'b1;
        push_exp(32'h5555_AAAA, 2'b00);
        step();                                   // AR
        bus.axi_start = 1'b0;
        step();                                   // R
        check("t6_in_r", 64'(dbg_state), 64'd2);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h5555_AAAA;
        resetn = 1'b0;
        step();
        exp_q.delete();
        check("t6_state",  64'(dbg_state), 64'd0);
        check("t6_rready", 64'(bus.rready), 64'd0);
        check("t6_done",   64'(bus.axi_done), 64'd0);
        check("t6_busy",   64'(bus.axi_busy), 64'd0);
        check("t6_araddr", 64'(bus.araddr), 64'd0);
        check("t6_rdata",  64'(bus.axi_rdata), 64'd0);
        resetn = 1'b1;
        step();
        step();
        step();
        bus.rvalid = 1'b0;
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        check("t6_still_idle", 64'(dbg_state), 64'd0);

        // final report
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
